mem_responder: RTL

- Memory-side responder for the multicycle core's load/store/fetch path; it answers the requests the control FSM issues (address, write strobe, write data).
- Word-organised synchronous RAM behind a req/ready handshake with a parameterised wait-state count.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-organised synchronous RAM responder with a req/ready handshake and fixed wait states.
// Optional per-byte write enables are compiled in with `define MEM_RESP_BYTE_WRITE_EN.
`timescale 1ns/1ps

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_RESP_BYTE_WRITE_EN
  input  logic [3:0]        be,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam int         LANE_W    = DATA_W / 4;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] word_addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              acc_err_reg;
  logic [DATA_W-1:0] rd_word_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [3:0]        be_eff;
  logic [DATA_W-1:0] merged_word;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              mem_we;
  logic              addr_misaligned;
  logic              addr_out_of_range;
  logic [ADDR_W-1:0] addr_word;

  assign addr_word         = addr[ADDR_W+1:2];
  assign addr_misaligned   = |addr[1:0];
  assign addr_out_of_range = |(addr >> (ADDR_W + 2));

  assign accept = (state_reg == ST_IDLE) && req;
  assign commit = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
  assign mem_we = commit && we_reg && !acc_err_reg;

`ifdef MEM_RESP_BYTE_WRITE_EN
  logic [3:0] be_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      be_reg <= 4'd0;
    end else if (accept) begin
      be_reg <= be;
    end
  end

  assign be_eff = be_reg;
`else
  assign be_eff = 4'hF;
`endif

  // The old word is fetched on the accept edge so a partial write can be merged
  // and echoed on the commit edge without a second RAM read port.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*LANE_W +: LANE_W] = be_eff[gi] ? wdata_reg[gi*LANE_W +: LANE_W]
                                                           : rd_word_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_reg <= mem[addr_word];
    end
    if (mem_we) begin
      mem[word_addr_reg] <= merged_word;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req) state_next = ST_WAIT;
      ST_WAIT: if (cnt_reg == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      word_addr_reg <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      acc_err_reg   <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            word_addr_reg <= addr_word;
            we_reg        <= we;
            wdata_reg     <= wdata;
            acc_err_reg   <= addr_misaligned || addr_out_of_range;
            cnt_reg       <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (acc_err_reg) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else if (we_reg) begin
            rdata_reg <= merged_word;
          end else begin
            rdata_reg <= rd_word_reg;
          end
        end
        ST_RESP: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end
        default: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign err   = err_reg;
  assign ready = (state_reg == ST_RESP);
  assign busy  = (state_reg != ST_IDLE);

endmodule
